pwm_capture_avalon_bridge: RTL
==============================

PWM_CAPTURE_AVALON_BRIDGE -- requirements
Module: pwm_capture_avalon_bridge

Interface
REQ-001 Parameter NUMBER_OF_CHANNELS, default 6: number of independent PWM input channels (1..32).
REQ-002 Parameter COUNTER_WIDTH, default 24: width of the high-time and period counters (8..32).
REQ-003 Parameter TIMEOUT_CYCLES, default 2_500_000: idle clocks before a channel is declared dead (50 ms at 50 MHz).
REQ-004 clk  input  1: single system clock; all logic is on its rising edge.
REQ-005 reset  input  1: asynchronous, active-low reset.
REQ-006 address  input  16: Avalon slave word address; only address[7:0] is decoded.
REQ-007 read  input  1: Avalon read strobe.
REQ-008 readdata  output  32: Avalon read data, registered.
REQ-009 write  input  1: Avalon write strobe.
REQ-010 writedata  input  32: Avalon write data.
REQ-011 PWM_in  input  NUMBER_OF_CHANNELS: asynchronous PWM inputs, one per channel.

Function
REQ-012 Each PWM_in bit SHALL pass a 2-flop synchronizer, then a third flop (prev); rise = sync & ~prev, fall = ~sync & prev.
REQ-013 Each channel SHALL run its own FSM with states WAIT_RISE, HIGH and LOW.
REQ-014 WAIT_RISE: on rise -> HIGH, with hcnt=1 and pcnt=1.
REQ-015 HIGH: hcnt and pcnt each increment per clock; on fall -> LOW, with hcnt frozen.
REQ-016 LOW: pcnt increments per clock; on rise the channel SHALL load HIGH_REG=hcnt and PERIOD_REG=pcnt, set valid[ch], restart hcnt=1 and pcnt=1, and go to HIGH, all on that same edge.
REQ-017 Measured values SHALL equal clock counts exactly for clean inputs: 100 clocks high in a 400-clock period gives 100/400.
REQ-018 Counters SHALL saturate at 2^COUNTER_WIDTH-1 and never wrap.
REQ-019 Register read values SHALL be zero-extended to 32 bits.
REQ-020 Timeout: an idle counter SHALL clear on every rise or fall and otherwise increment.
REQ-021 On reaching TIMEOUT_CYCLES in any state, the channel SHALL:
 - go to WAIT_RISE;
 - clear HIGH_REG, PERIOD_REG and valid[ch];
 - set sticky timeout[ch].
REQ-022 Address map (word addresses, address[7:0]):
 - ch (0..N-1) = HIGH_REG[ch];
 - N+ch = PERIOD_REG[ch];
 - 2N = STATUS, with valid in bits[15:0] and timeout in bits[31:16] for ch<16;
 - 2N+1 = CONTROL, which reads 0.
REQ-023 Read latency SHALL be 1: readdata is registered on the edge where read=1 and holds until the next read.
REQ-024 Reading an undecoded address SHALL return 0.
REQ-025 readdata SHALL show the register value from before any capture on the same edge as the read.
REQ-026 A write to CONTROL with bit0=1 SHALL clear all valid and timeout bits.
REQ-027 A write to CONTROL with bit1=1 SHALL force every channel FSM to WAIT_RISE and clear its counters.
REQ-028 A write to any other address SHALL be ignored.
REQ-029 If a clear and a set of the same valid or timeout bit happen on the same edge, the set SHALL win.
REQ-030 Simultaneous read and write SHALL both take effect; the read returns the pre-write value.

Reset
REQ-031 While reset=0, the following SHALL be 0 or cleared: readdata, all HIGH_REG/PERIOD_REG, valid, timeout, all counters and synchronizer flops, and every FSM (forced to WAIT_RISE).
REQ-032 Reset asserted mid-measurement SHALL abort it; after release, the first partial pulse SHALL NOT produce a capture, because the FSM waits for a rise.

Verification
REQ-033 The bench SHALL cover reset release with PWM_in=0 and reads of addresses 0..2N+1 -> all return 0.
REQ-034 The bench SHALL drive ch0 with 100 high / 300 low for 3 periods -> after the 2nd rise plus 3 clocks:
 - addr 0 = 100;
 - addr N = 400;
 - STATUS bit0 = 1;
 - other channels read 0.
REQ-035 The bench SHALL drive ch1 steady high for TIMEOUT_CYCLES+5 clocks (TIMEOUT_CYCLES set to 1000 for sim) -> addr 1 = 0, addr N+1 = 0, STATUS bit17 = 1, bit1 = 0.
REQ-036 The bench SHALL cover COUNTER_WIDTH=8 with a 300-clock-high, 600-clock period -> HIGH_REG=255, PERIOD_REG=255 (saturated).
REQ-037 The bench SHALL write CONTROL=1 on the same edge as the ch0 capture -> valid bit0 remains 1; bit17 is cleared.
REQ-038 The bench SHALL assert reset for 2 clocks in the middle of a ch0 high phase, then continue the 100/400 waveform -> no capture on the first fall; the first valid capture (100/400) follows the 2nd full rise after release.

Source files
------------

// File: rtl/pwm_capture_avalon_bridge_if.sv
// Avalon-MM slave bus bundle for the PWM capture bridge.
// Signals: address[15:0], read, write, writedata[31:0] in; readdata[31:0] out.
interface pwm_capture_avalon_bridge_if;
    logic [15:0] address;
    logic        read;
    logic [31:0] readdata;
    logic        write;
    logic [31:0] writedata;

    modport master (
        output address,
        output read,
        output write,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  read,
        input  write,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/pwm_capture_avalon_bridge.sv
// Multi-channel PWM high-time/period capture with an Avalon-MM register file.
// Ports: clk, reset (async active-low), avs (Avalon slave), PWM_in[N-1:0].
module pwm_capture_avalon_bridge #(
    parameter int NUMBER_OF_CHANNELS = 6,
    parameter int COUNTER_WIDTH      = 24,
    parameter int TIMEOUT_CYCLES     = 2_500_000
) (
    input  logic                          clk,
    input  logic                          reset,
    pwm_capture_avalon_bridge_if.slave    avs,
    input  logic [NUMBER_OF_CHANNELS-1:0] PWM_in
);
    localparam int N   = NUMBER_OF_CHANNELS;
    localparam int CW  = COUNTER_WIDTH;
    localparam int IW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LIM = (N < 16) ? N : 16;

    localparam logic [CW-1:0] CMAX      = '1;
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    A_STATUS  = 8'(2 * N);
    localparam logic [7:0]    A_CONTROL = 8'(2 * N + 1);

    typedef enum logic [1:0] {
        WAIT_RISE,
        HIGH,
        LOW
    } state_t;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
        return (x == CMAX) ? x : x + CW'(1);
    endfunction

    logic [N-1:0]  sync1, sync2, prev;
    logic [1:0]    warm;
    logic          edges_ok;
    logic [N-1:0]  rise, fall;

    state_t        state   [N];
    state_t        state_n [N];
    logic [CW-1:0] hcnt    [N];
    logic [CW-1:0] hcnt_n  [N];
    logic [CW-1:0] pcnt    [N];
    logic [CW-1:0] pcnt_n  [N];
    logic [CW-1:0] high_r  [N];
    logic [CW-1:0] high_n  [N];
    logic [CW-1:0] per_r   [N];
    logic [CW-1:0] per_n   [N];
    logic [IW-1:0] idle    [N];
    logic [IW-1:0] idle_n  [N];

    logic [N-1:0]  valid, valid_n, tmo, tmo_n;
    logic [N-1:0]  cap, expire;
    logic          ctrl_wr, clr_sticky, force_idle;
    logic [31:0]   status, rdata_n, rdata_q;
    logic [7:0]    a;
    logic          unused_bits;

    assign unused_bits = ^{avs.address[15:8], avs.writedata[31:2]};

    // Synchronizer plus edge-detect flop. The warm-up count masks edges
    // until the chain has refilled after reset, so an input already high
    // at release does not look like a fresh rise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
            warm  <= '0;
        end else begin
            sync1 <= PWM_in;
            sync2 <= sync1;
            prev  <= sync2;
            if (warm != 2'd3)
                warm <= warm + 2'd1;
        end
    end

    assign edges_ok = (warm == 2'd3);
    assign rise = edges_ok ? (sync2 & ~prev) : '0;
    assign fall = edges_ok ? (~sync2 & prev) : '0;

    assign a          = avs.address[7:0];
    assign ctrl_wr    = avs.write && (a == A_CONTROL);
    assign clr_sticky = ctrl_wr & avs.writedata[0];
    assign force_idle = ctrl_wr & avs.writedata[1];

    // Per-channel next-state logic.
    always_comb begin
        cap    = '0;
        expire = '0;
        for (int ch = 0; ch < N; ch++) begin
            state_n[ch] = state[ch];
            hcnt_n[ch]  = hcnt[ch];
            pcnt_n[ch]  = pcnt[ch];
            high_n[ch]  = high_r[ch];
            per_n[ch]   = per_r[ch];
            idle_n[ch]  = idle[ch];

            if (rise[ch] | fall[ch]) begin
                idle_n[ch] = '0;
            end else if (idle[ch] == IDLE_LAST) begin
                idle_n[ch] = '0;
                expire[ch] = !force_idle;
            end else begin
                idle_n[ch] = idle[ch] + IW'(1);
            end

            if (force_idle) begin
                state_n[ch] = WAIT_RISE;
                hcnt_n[ch]  = '0;
                pcnt_n[ch]  = '0;
                idle_n[ch]  = '0;
            end else if (expire[ch]) begin
                state_n[ch] = WAIT_RISE;
                hcnt_n[ch]  = '0;
                pcnt_n[ch]  = '0;
                high_n[ch]  = '0;
                per_n[ch]   = '0;
            end else begin
                case (state[ch])
                    WAIT_RISE: begin
                        if (rise[ch]) begin
                            state_n[ch] = HIGH;
                            hcnt_n[ch]  = CW'(1);
                            pcnt_n[ch]  = CW'(1);
                        end
                    end
                    HIGH: begin
                        pcnt_n[ch] = sat_inc(pcnt[ch]);
                        if (fall[ch])
                            state_n[ch] = LOW;
                        else
                            hcnt_n[ch] = sat_inc(hcnt[ch]);
                    end
                    LOW: begin
                        if (rise[ch]) begin
                            high_n[ch]  = hcnt[ch];
                            per_n[ch]   = pcnt[ch];
                            cap[ch]     = 1'b1;
                            state_n[ch] = HIGH;
                            hcnt_n[ch]  = CW'(1);
                            pcnt_n[ch]  = CW'(1);
                        end else begin
                            pcnt_n[ch] = sat_inc(pcnt[ch]);
                        end
                    end
                    default: begin
                        state_n[ch] = WAIT_RISE;
                    end
                endcase
            end
        end
    end

    // Sets beat a same-edge clear from CONTROL.
    assign valid_n = (valid & ~{N{clr_sticky}} & ~expire) | cap;
    assign tmo_n   = (tmo & ~{N{clr_sticky}}) | expire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int ch = 0; ch < N; ch++) begin
                state[ch]  <= WAIT_RISE;
                hcnt[ch]   <= '0;
                pcnt[ch]   <= '0;
                high_r[ch] <= '0;
                per_r[ch]  <= '0;
                idle[ch]   <= '0;
            end
            valid <= '0;
            tmo   <= '0;
        end else begin
            for (int ch = 0; ch < N; ch++) begin
                state[ch]  <= state_n[ch];
                hcnt[ch]   <= hcnt_n[ch];
                pcnt[ch]   <= pcnt_n[ch];
                high_r[ch] <= high_n[ch];
                per_r[ch]  <= per_n[ch];
                idle[ch]   <= idle_n[ch];
            end
            valid <= valid_n;
            tmo   <= tmo_n;
        end
    end

    always_comb begin
        status = '0;
        for (int ch = 0; ch < LIM; ch++) begin
            status[ch]      = valid[ch];
            status[16 + ch] = tmo[ch];
        end
    end

    // Read mux works on current register values, so a read on a capture
    // edge returns the pre-capture contents.
    always_comb begin
        rdata_n = '0;
        for (int ch = 0; ch < N; ch++) begin
            if (a == 8'(ch))
                rdata_n = 32'(high_r[ch]);
            if (a == 8'(N + ch))
                rdata_n = 32'(per_r[ch]);
        end
        if (a == A_STATUS)
            rdata_n = status;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rdata_q <= '0;
        else if (avs.read)
            rdata_q <= rdata_n;
    end

    assign avs.readdata = rdata_q;
endmodule
